// File: rtl/load_store_requester.sv
// load_store_requester: initiator side of the byte-lane BRAM port.
// Turns CPU load/store requests into word-aligned memory accesses. An access
// that straddles a word boundary is split into two word accesses. Load data
// is realigned and sign/zero-extended.
// Optional build macro: LSR_MISALIGN_TRAP_EN. When defined, a straddling
// request issues no memory access and completes at once with rsp_error set.
module load_store_requester #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [4:0]        memory_access_code,
  output logic [ADDR_W-1:0] memory_address,
  output logic [DATA_W-1:0] data_to_store,
  input  logic [DATA_W-1:0] writeback_register_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_ISSUE1 = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_req_ready;
  logic [4:0]          r_code;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_error;

  // Request fields held for the whole transaction
  logic [1:0]          r_off;
  logic [1:0]          r_size;
  logic                r_signed;
  logic                r_is_store;
  logic [7:0]          r_mask;
  logic [2*DATA_W-1:0] r_svec;
  logic [ADDR_W-1:0]   r_w1;
  logic                r_split;
  logic                r_trap;
  logic [DATA_W-1:0]   r_word0;
  logic [DATA_W-1:0]   r_word1;

  // Decode of the request currently on the inputs
  logic                w_accept;
  logic [1:0]          w_req_off;
  logic [7:0]          w_req_base;
  logic [7:0]          w_req_mask;
  logic [2*DATA_W-1:0] w_req_svec;
  logic [ADDR_W-1:0]   w_req_w0;
  logic                w_req_split;
  logic                w_req_trap;

  logic [4:0]          w_code_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic [DATA_W-1:0]   w_shifted;
  logic [DATA_W-1:0]   w_load_res;

  assign w_accept    = (r_state == ST_IDLE) && req_valid;
  assign w_req_off   = req_addr[1:0];
  assign w_req_mask  = w_req_base << w_req_off;
  assign w_req_svec  = {{DATA_W{1'b0}}, req_wdata} << {w_req_off, 3'b000};
  assign w_req_w0    = {req_addr[ADDR_W-1:2], 2'b00};
  assign w_req_split = |w_req_mask[7:4];

`ifdef LSR_MISALIGN_TRAP_EN
  assign w_req_trap = w_req_split;
`else
  assign w_req_trap = 1'b0;
`endif

  // Lane mask before positioning: one bit per byte of the access size
  always_comb begin
    w_req_base = 8'h0F;
    case (req_size)
      2'b00:   w_req_base = 8'h01;
      2'b01:   w_req_base = 8'h03;
      default: w_req_base = 8'h0F;
    endcase
  end

  // Next state and the memory outputs to present in that state
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = 5'b0_0000;
    w_addr_nxt  = {ADDR_W{1'b0}};
    w_data_nxt  = {DATA_W{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_req_trap) begin
            w_state_nxt = ST_RESP;
          end else begin
            // First access is built straight from the inputs being accepted
            w_state_nxt = ST_ISSUE0;
            w_code_nxt  = {req_is_store, w_req_mask[3:0]};
            w_addr_nxt  = w_req_w0;
            w_data_nxt  = w_req_svec[DATA_W-1:0];
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE0: begin
        if (r_split) begin
          w_state_nxt = ST_ISSUE1;
          w_code_nxt  = {r_is_store, r_mask[7:4]};
          w_addr_nxt  = r_w1;
          w_data_nxt  = r_svec[2*DATA_W-1:DATA_W];
        end else if (!r_is_store) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_ISSUE1: begin
        if (r_is_store) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Realign the captured words and extend to the requested size
  always_comb begin
    w_shifted  = DATA_W'({r_word1, r_word0} >> {r_off, 3'b000});
    w_load_res = {DATA_W{1'b0}};
    if (r_is_store || r_trap) begin
      w_load_res = {DATA_W{1'b0}};
    end else begin
      case (r_size)
        2'b00:   w_load_res = {{(DATA_W-8){r_signed & w_shifted[7]}}, w_shifted[7:0]};
        2'b01:   w_load_res = {{(DATA_W-16){r_signed & w_shifted[15]}}, w_shifted[15:0]};
        default: w_load_res = w_shifted;
      endcase
    end
  end

  // State register and all registered outputs
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_code      <= 5'b0_0000;
      r_addr      <= {ADDR_W{1'b0}};
      r_data      <= {DATA_W{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= {DATA_W{1'b0}};
      r_rsp_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_code      <= w_code_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_rsp_valid <= (r_state == ST_RESP);
      r_rsp_error <= (r_state == ST_RESP) && r_trap;
      if (r_state == ST_RESP) begin
        r_rsp_data <= w_load_res;
      end
    end
  end

  // Latch the request on accept; inputs are ignored afterwards
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_off      <= 2'b00;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_is_store <= 1'b0;
      r_mask     <= 8'h00;
      r_svec     <= {(2*DATA_W){1'b0}};
      r_w1       <= {ADDR_W{1'b0}};
      r_split    <= 1'b0;
      r_trap     <= 1'b0;
    end else if (w_accept) begin
      r_off      <= w_req_off;
      r_size     <= req_size;
      r_signed   <= req_signed;
      r_is_store <= req_is_store;
      r_mask     <= w_req_mask;
      r_svec     <= w_req_svec;
      r_w1       <= w_req_w0 + WORD_STEP;
      r_split    <= w_req_split;
      r_trap     <= w_req_trap;
    end
  end

  // Capture read data, which trails its access by one cycle
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_word0 <= {DATA_W{1'b0}};
      r_word1 <= {DATA_W{1'b0}};
    end else if ((r_state == ST_ISSUE1) && !r_is_store) begin
      r_word0 <= writeback_register_data;
    end else if (r_state == ST_DRAIN) begin
      if (r_split) begin
        r_word1 <= writeback_register_data;
      end else begin
        r_word0 <= writeback_register_data;
      end
    end
  end

  assign req_ready          = r_req_ready;
  assign memory_access_code = r_code;
  assign memory_address     = r_addr;
  assign data_to_store      = r_data;
  assign rsp_valid          = r_rsp_valid;
  assign rsp_data           = r_rsp_data;
  assign rsp_error          = r_rsp_error;

endmodule

// File: tb/tb_load_store_requester.sv
// Scoreboard bench for load_store_requester: directed requests push expected
// memory accesses and responses; a negedge monitor pops and compares.
module tb_load_store_requester;

`ifdef LSR_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [4:0]  code;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc_cyc;
    int          lat;
  } rsp_t;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  memory_access_code;
  logic [31:0] memory_address;
  logic [31:0] data_to_store;
  logic [31:0] writeback_register_data = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;

  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  acc_t acc_q[$];
  rsp_t rsp_q[$];
  acc_t m_acc;
  rsp_t m_rsp;
  logic [31:0] mem [16] = '{default: 32'h0};

  load_store_requester dut (
    .CLOCK_50               (CLOCK_50),
    .resetn                 (resetn),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_is_store           (req_is_store),
    .req_size               (req_size),
    .req_signed             (req_signed),
    .req_addr               (req_addr),
    .req_wdata              (req_wdata),
    .memory_access_code     (memory_access_code),
    .memory_address         (memory_address),
    .data_to_store          (data_to_store),
    .writeback_register_data(writeback_register_data),
    .rsp_valid              (rsp_valid),
    .rsp_data               (rsp_data),
    .rsp_error              (rsp_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Byte-lane BRAM model: 16 words, read data one cycle after the access
  always @(posedge CLOCK_50) begin
    if (memory_access_code != 5'b0_0000) begin
      if (memory_access_code[4]) begin
        for (int k = 0; k < 4; k++)
          if (memory_access_code[k])
            mem[memory_address[5:2]][8*k +: 8] <= data_to_store[8*k +: 8];
      end else begin
        writeback_register_data <= mem[memory_address[5:2]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every non-idle access and every response is popped and compared
  always @(negedge CLOCK_50) begin
    if (resetn) begin
      if (memory_access_code != 5'b0_0000) begin
        if (acc_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL acc_unexpected: got code %b addr %h, none expected", memory_access_code, memory_address);
        end else begin
          m_acc = acc_q.pop_front();
          chk("acc_code", {27'h0, memory_access_code}, {27'h0, m_acc.code});
          chk("acc_addr", memory_address, m_acc.addr);
          chk("acc_data", data_to_store, m_acc.data);
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL rsp_unexpected: got data %h err %b, none expected", rsp_data, rsp_error);
        end else begin
          m_rsp = rsp_q.pop_front();
          chk("rsp_data", rsp_data, m_rsp.data);
          chk("rsp_error", {31'h0, rsp_error}, {31'h0, m_rsp.err});
          chk("rsp_latency", 32'(cyc - m_rsp.acc_cyc), 32'(m_rsp.lat));
        end
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge CLOCK_50);
    if (!req_ready) begin
      n_vec++; n_miss++;
      $display("FAIL ready_timeout: got req_ready 0 expected 1");
    end
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 30 && (rsp_q.size() != 0 || acc_q.size() != 0); i++) @(negedge CLOCK_50);
    if (rsp_q.size() != 0 || acc_q.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL rsp_timeout: got %0d pending responses %0d pending accesses expected 0", rsp_q.size(), acc_q.size());
      rsp_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic do_req(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd, input int n,
                        input logic [4:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic [4:0] c1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic [31:0] rd, input logic er, input int lat);
    @(negedge CLOCK_50);
    wait_ready();
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    if (n > 0) acc_q.push_back(acc_t'{c0, a0, d0});
    if (n > 1) acc_q.push_back(acc_t'{c1, a1, d1});
    rsp_q.push_back(rsp_t'{rd, er, cyc + 1, lat});
    @(negedge CLOCK_50);
    req_valid = 1'b0; req_wdata = 32'h0;
    wait_rsp();
  endtask

  // Straddling request: two accesses normally, an immediate error when trapping
  task automatic split_req(input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd,
                           input logic [4:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                           input logic [4:0] c1, input logic [31:0] a1, input logic [31:0] d1,
                           input logic [31:0] rd, input int lat);
    if (TRAP) do_req(st, sz, sg, ad, wd, 0, c0, a0, d0, c1, a1, d1, 32'h0, 1'b1, 1);
    else      do_req(st, sz, sg, ad, wd, 2, c0, a0, d0, c1, a1, d1, rd, 1'b0, lat);
  endtask

  initial begin
    int accepts;
    int last_acc;
    repeat (3) @(negedge CLOCK_50);
    chk("reset_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_code", {27'h0, memory_access_code}, 32'h0);
    chk("reset_addr", memory_address, 32'h0);
    chk("reset_data", data_to_store, 32'h0);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_rsp_error", {31'h0, rsp_error}, 32'h0);
    resetn = 1'b1;

    do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'hF0F1F2F3, 1, 5'b11111, 32'h0, 32'hF0F1F2F3, 5'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2);
    do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'hA0A1A2A3, 1, 5'b11111, 32'h4, 32'hA0A1A2A3, 5'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2);
    do_req(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 1, 5'b00010, 32'h4, 32'h0, 5'b0, 32'h0, 32'h0, 32'hFFFFFFA2, 1'b0, 3);
    do_req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 1, 5'b00010, 32'h4, 32'h0, 5'b0, 32'h0, 32'h0, 32'h000000A2, 1'b0, 3);
    split_req(1'b1, 2'b10, 1'b0, 32'h6, 32'h11223344, 5'b11100, 32'h4, 32'h33440000, 5'b10011, 32'h8, 32'h00001122, 32'h0, 3);
    split_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 5'b01100, 32'h4, 32'h0, 5'b00011, 32'h8, 32'h0, 32'h11223344, 4);
    split_req(1'b0, 2'b01, 1'b0, 32'h7, 32'h0, 5'b01000, 32'h4, 32'h0, 5'b00001, 32'h8, 32'h0, 32'h00002233, 4);
    do_req(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 1, 5'b01100, 32'h0, 32'h0, 5'b0, 32'h0, 32'h0, 32'hFFFFF0F1, 1'b0, 3);
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1, 5'b01111, 32'h0, 32'h0, 5'b0, 32'h0, 32'h0, 32'hF0F1F2F3, 1'b0, 3);
    do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h000000AB, 1, 5'b10010, 32'h8, 32'h0000AB00, 5'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2);
    do_req(1'b1, 2'b01, 1'b0, 32'hC, 32'h0000BEEF, 1, 5'b10011, 32'hC, 32'h0000BEEF, 5'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2);
    do_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 1, 5'b00010, 32'h8, 32'h0, 5'b0, 32'h0, 32'h0, 32'hFFFFFFAB, 1'b0, 3);
    do_req(1'b0, 2'b01, 1'b1, 32'hC, 32'h0, 1, 5'b00011, 32'hC, 32'h0, 5'b0, 32'h0, 32'h0, 32'hFFFFBEEF, 1'b0, 3);
    split_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 5'b01100, 32'hFFFFFFFC, 32'h0, 5'b00011, 32'h0, 32'h0, 32'hF2F30000, 4);

    // Reset in the middle of a straddling load: abandoned, no response
    @(negedge CLOCK_50);
    wait_ready();
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h6;
    if (!TRAP) acc_q.push_back(acc_t'{5'b01100, 32'h4, 32'h0});
    @(posedge CLOCK_50);
    #1 req_valid = 1'b0;
    if (!TRAP) @(posedge CLOCK_50);
    #1 resetn = 1'b0;
    #1;
    chk("midreset_code", {27'h0, memory_access_code}, 32'h0);
    chk("midreset_addr", memory_address, 32'h0);
    chk("midreset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (6) @(negedge CLOCK_50);
    chk("midreset_ready", {31'h0, req_ready}, 32'h1);
    chk("midreset_pending", 32'(acc_q.size() + rsp_q.size()), 32'h0);

    // req_valid held high: one accept per IDLE, accepts four cycles apart
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h5;
    accepts = 0;
    last_acc = -1;
    for (int c = 0; c < 40 && accepts < 3; c++) begin
      if (req_ready) begin
        acc_q.push_back(acc_t'{5'b00010, 32'h4, 32'h0});
        rsp_q.push_back(rsp_t'{32'h000000A2, 1'b0, cyc + 1, 3});
        if (last_acc >= 0) chk("accept_gap", 32'(cyc + 1 - last_acc), 32'd4);
        last_acc = cyc + 1;
        accepts++;
      end
      @(negedge CLOCK_50);
    end
    req_valid = 1'b0;
    chk("hold_accepts", 32'(accepts), 32'd3);
    wait_rsp();
    repeat (4) @(negedge CLOCK_50);
    chk("final_pending", 32'(acc_q.size() + rsp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/load_store_requester.md
Name: load_store_requester

Overview:
- Initiator side of the byte-lane BRAM memory port: turns CPU load/store requests into `memory_access_code` / `memory_address` / `data_to_store` transactions.
- Consumes `writeback_register_data`, which arrives one cycle after a read is issued.
- Splits accesses that straddle a word boundary into two word accesses, then realigns and sign/zero-extends load data.
- Sits between the CPU memory stage and the BRAM addresser.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width. Fixed at 32; 4 byte lanes.

Ports:
- `CLOCK_50`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  requester idle; a request is accepted when `req_valid` and `req_ready` are both high at a clock edge.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `req_signed`  in  1  loads only: sign-extend (1) or zero-extend (0).
- `req_addr`  in  32  byte address, any alignment.
- `req_wdata`  in  32  store data, right-justified.
- `memory_access_code`  out  5  [4] = write, [3:0] = byte-lane enables.
- `memory_address`  out  32  word-aligned address; bits [1:0] always 0.
- `data_to_store`  out  32  lane-positioned store data.
- `writeback_register_data`  in  32  read data; valid the cycle after a read access is driven.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_data`  out  32  extended load result; 0 for stores.
- `rsp_error`  out  1  misalignment trap (see Optional Feature).

Behaviour:
- **Lane convention:** lane k = bits [8k+7:8k] = byte at word_base+k (little-endian).
- **Reset (async, `resetn` low):**
  - state=IDLE, `req_ready`=1.
  - `memory_access_code`=5'b0_0000, `memory_address`=0, `data_to_store`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_error`=0.
  - A reset mid-transaction abandons it: no response is produced and the memory outputs drop to no-op immediately.
- **Outputs:** all are registered. Outside the ISSUE states `memory_access_code` is 5'b0_0000.
- **On accept, latch:**
  - off = addr[1:0]
  - n = 1, 2 or 4 bytes
  - lane mask m[7:0] = ((1<<n)-1) << off
  - store vector s[63:0] = wdata << (8*off)
  - w0 = {addr[31:2],2'b00}
  - w1 = w0+4, wrapping 0xFFFFFFFC -> 0x00000000
  - split = |m[7:4]
- **FSM: IDLE -> ISSUE0 -> [ISSUE1] -> [DRAIN] -> RESP -> IDLE**
  - IDLE: `req_ready`=1. On accept go to ISSUE0; `req_ready` deasserts the next cycle.
  - ISSUE0: address=w0, code={store, m[3:0]}, data=s[31:0].
    - Next state: split -> ISSUE1; else load -> DRAIN; else RESP.
  - ISSUE1: address=w1, code={store, m[7:4]}, data=s[63:32].
    - Load: capture `writeback_register_data` as word0 this cycle.
    - Next state: load -> DRAIN; store -> RESP.
  - DRAIN: no-op code. Capture `writeback_register_data` as word1 if split, else as word0. Next state RESP.
  - RESP: `rsp_valid`=1 for exactly one cycle, then IDLE.
- **Load result:** ({word1,word0} >> 8*off) truncated to n bytes, then sign- or zero-extended per `req_signed`.
- **Store response:** `rsp_data`=0.
- **Latency, accept edge to `rsp_valid` high:**
  - aligned store: 2 cycles
  - aligned load: 3
  - split store: 3
  - split load: 4
- **Back-pressure:** `req_valid` while busy is ignored (no queueing). Request inputs are not sampled after accept.
- **Byte enables:** an all-zero enable nibble is never issued in ISSUE states.

Optional Feature:
- Macro: `LSR_MISALIGN_TRAP_EN`.
- Defined: a split request issues no memory access. The FSM goes IDLE -> RESP with `rsp_valid`=1, `rsp_error`=1, `rsp_data`=0. Aligned requests are unchanged.
- Undefined: split requests proceed as above; `rsp_error` is tied 0.

Test Plan:
- **Aligned word store:** store word addr 0x0 data F0F1F2F3 -> one ISSUE cycle with code 1_1111, addr 0, data F0F1F2F3. `rsp_valid` 2 cycles after accept, `rsp_data`=0.
- **Signed byte load:** with word@4 = A0A1A2A3, load byte signed addr 5 -> code 0_0010 addr 4, `rsp_data`=FFFFFFA2. Same request unsigned -> 000000A2.
- **Split store:** store word addr 6 data 11223344 -> access0: addr 4, code 1_1100, data 33440000. Access1: addr 8, code 1_0011, data 00001122. Follow with load word addr 6 -> 11223344 after 4 cycles.
- **Split half load:** after the previous test, load half unsigned addr 7 -> addr 4 code 0_1000, then addr 8 code 0_0001, `rsp_data`=00002233. With `LSR_MISALIGN_TRAP_EN` defined: no access issued, `rsp_error`=1.
- **Address wrap:** load word addr FFFFFFFE -> accesses to FFFFFFFC then 00000000.
- **Reset and busy behaviour:**
  - Pull `resetn` low during ISSUE1 -> code 0_0000 immediately, no `rsp_valid`, `req_ready`=1 after release.
  - Hold `req_valid` high throughout -> exactly one accept per IDLE.
